serial_subtractor: RTL and testbench

Bit-serial unsigned/two's-complement subtractor computing A − B, LSB first, one bit per clock. It is the subtraction counterpart to the team's half-adder/adder datapath. A single full-subtractor cell (difference + borrow) is reused every cycle, with a borrow flip-flop carried between bits. Operands are accepted with a ready/valid handshake. The result is held under ready/valid back-pressure for a downstream consumer.

---
 rtl/serial_subtractor_pkg.sv | 14 +
 rtl/serial_subtractor_full_subtractor.sv | 13 +
 rtl/serial_subtractor.sv | 110 +++++++++++
 tb/tb_serial_subtractor.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_subtractor_pkg.sv
// Shared types and sizing helpers for the bit-serial subtractor.
package serial_subtractor_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit full subtractor: difference and borrow-out of a - b - bin.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial A - B, LSB first, with ready/valid on operands and result.
//
// state | meaning
// IDLE  | waiting for operands, in_ready high
// SHIFT | one difference bit per clock through the shared cell
// DONE  | result presented, held until out_ready
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             ovf
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t state, state_nx;

  logic [WIDTH-1:0] a_sh, b_sh;
  logic [WIDTH-2:0] result_lo;
  logic [WIDTH-1:0] result_nx;
  logic [CW-1:0]    cnt;
  logic             borrow_q;
  logic             a_msb, b_msb;
  logic             d_bit, bo_bit;

  full_subtractor u_fs (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .bin  (borrow_q),
    .d    (d_bit),
    .bout (bo_bit)
  );

  // Result register holds the low WIDTH-1 bits; the new bit enters at the MSB.
  assign result_nx = {d_bit, result_lo};

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (in_valid) state_nx = SHIFT;
      SHIFT:   if (cnt == LAST) state_nx = DONE;
      DONE:    if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_sh      <= '0;
      b_sh      <= '0;
      result_lo <= '0;
      cnt       <= '0;
      borrow_q  <= 1'b0;
      a_msb     <= 1'b0;
      b_msb     <= 1'b0;
      diff      <= '0;
      borrow    <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sh      <= a;
            b_sh      <= b;
            result_lo <= '0;
            cnt       <= '0;
            borrow_q  <= 1'b0;
            a_msb     <= a[WIDTH-1];
            b_msb     <= b[WIDTH-1];
          end
        end
        SHIFT: begin
          a_sh      <= a_sh >> 1;
          b_sh      <= b_sh >> 1;
          result_lo <= result_nx[WIDTH-1:1];
          borrow_q  <= bo_bit;
          cnt       <= cnt + CW'(1);
          // Output registers load only on the final bit so they keep the last result afterwards.
          if (cnt == LAST) begin
            diff   <= result_nx;
            borrow <= bo_bit;
            ovf    <= (a_msb ^ b_msb) & (d_bit ^ a_msb);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor against an arithmetic reference model.
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a, b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] diff;
  logic         borrow;
  logic         ovf;

  int pass_cnt = 0;
  int total_cnt = 0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .borrow    (borrow),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  // Reference: plain integer arithmetic on the unsigned and signed views.
  function automatic void ref_sub(input logic [W-1:0] x, input logic [W-1:0] y,
                                  output logic [W-1:0] d, output logic bo, output logic ov);
    int sx, sy, r;
    int ux, uy;
    ux = int'(x);
    uy = int'(y);
    d  = W'(ux - uy);
    bo = (ux < uy);
    sx = x[W-1] ? ux - (1 << W) : ux;
    sy = y[W-1] ? uy - (1 << W) : uy;
    r  = sx - sy;
    ov = (r < -(1 << (W-1))) || (r > (1 << (W-1)) - 1);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input logic [W-1:0] x, input logic [W-1:0] y);
    total_cnt++;
    if (in_ready !== 1'b1) $display("FAIL accept_in_ready: got %b want 1", in_ready);
    else pass_cnt++;
    a = x;
    b = y;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 100) begin
      tick();
      lat++;
    end
    if (lat >= 100) begin
      total_cnt++;
      $display("FAIL wait_done_timeout: out_valid=%b after %0d cycles", out_valid, lat);
    end
  endtask

  task automatic release_result(input logic [W-1:0] d_exp);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    total_cnt++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL release_handshake: out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
    else pass_cnt++;
    total_cnt++;
    if (diff !== d_exp) $display("FAIL release_diff_hold: got %h want %h", diff, d_exp);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a = '0;
    b = '0;
    repeat (3) tick();
    rst_n = 1'b1;
    total_cnt++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0)
      $display("FAIL reset_handshake: in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
    else pass_cnt++;
    total_cnt++;
    if (diff !== '0 || borrow !== 1'b0 || ovf !== 1'b0)
      $display("FAIL reset_outputs: diff=%h borrow=%b ovf=%b want 0", diff, borrow, ovf);
    else pass_cnt++;
  endtask

  task automatic test_directed();
    logic [W-1:0] va [5];
    logic [W-1:0] vb [5];
    logic [W-1:0] vd [5];
    logic         vbo[5];
    logic         vov[5];
    int lat;
    va = '{8'h5A, 8'h00, 8'hFF, 8'h80, 8'h7F};
    vb = '{8'h3C, 8'h01, 8'hFF, 8'h01, 8'hFF};
    vd = '{8'h1E, 8'hFF, 8'h00, 8'h7F, 8'h80};
    vbo = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    vov = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 5; i++) begin
      accept(va[i], vb[i]);
      wait_done(lat);
      total_cnt++;
      if (lat !== W) $display("FAIL directed_latency[%0d]: got %0d want %0d", i, lat, W);
      else pass_cnt++;
      total_cnt++;
      if (diff !== vd[i] || borrow !== vbo[i] || ovf !== vov[i])
        $display("FAIL directed_result[%0d]: got %h/%b/%b want %h/%b/%b",
                 i, diff, borrow, ovf, vd[i], vbo[i], vov[i]);
      else pass_cnt++;
      release_result(vd[i]);
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] d_exp;
    logic bo_exp, ov_exp;
    int lat;
    ref_sub(8'hC3, 8'h5A, d_exp, bo_exp, ov_exp);
    accept(8'hC3, 8'h5A);
    repeat (2) tick();
    a = 8'h11;
    b = 8'h22;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    wait_done(lat);
    for (int i = 0; i < 20; i++) begin
      a = W'($urandom);
      b = W'($urandom);
      in_valid = 1'b1;
      total_cnt++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || diff !== d_exp ||
          borrow !== bo_exp || ovf !== ov_exp)
        $display("FAIL hold[%0d]: v=%b r=%b %h/%b/%b want 1/0 %h/%b/%b",
                 i, out_valid, in_ready, diff, borrow, ovf, d_exp, bo_exp, ov_exp);
      else pass_cnt++;
      tick();
    end
    in_valid = 1'b0;
    release_result(d_exp);
  endtask

  task automatic test_mid_reset();
    int lat;
    accept(8'hAB, 8'h12);
    repeat (4) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    total_cnt++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0)
      $display("FAIL midreset_handshake: in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
    else pass_cnt++;
    total_cnt++;
    if (diff !== '0 || borrow !== 1'b0 || ovf !== 1'b0)
      $display("FAIL midreset_outputs: diff=%h borrow=%b ovf=%b want 0", diff, borrow, ovf);
    else pass_cnt++;
    accept(8'h10, 8'h01);
    wait_done(lat);
    total_cnt++;
    if (diff !== 8'h0F || borrow !== 1'b0 || ovf !== 1'b0)
      $display("FAIL midreset_fresh: got %h/%b/%b want 0f/0/0", diff, borrow, ovf);
    else pass_cnt++;
    release_result(8'h0F);
  endtask

  task automatic test_back_to_back();
    logic [2*W-1:0] q[$];
    logic [2*W-1:0] pr;
    logic [W-1:0] x, y, d_exp;
    logic bo_exp, ov_exp;
    int done_cnt, cyc, last;
    done_cnt = 0;
    cyc = 0;
    last = -1;
    out_ready = 1'b1;
    in_valid = 1'b1;
    while (done_cnt < 1000 && cyc < 20000) begin
      if (out_valid === 1'b1) begin
        total_cnt++;
        if (q.size() == 0) begin
          $display("FAIL b2b_unexpected_result: diff=%h with no pending operands", diff);
        end else begin
          pr = q.pop_front();
          ref_sub(pr[2*W-1:W], pr[W-1:0], d_exp, bo_exp, ov_exp);
          if (diff !== d_exp || borrow !== bo_exp || ovf !== ov_exp)
            $display("FAIL b2b_result[%0d]: %h-%h got %h/%b/%b want %h/%b/%b", done_cnt,
                     pr[2*W-1:W], pr[W-1:0], diff, borrow, ovf, d_exp, bo_exp, ov_exp);
          else pass_cnt++;
        end
        if (last >= 0) begin
          total_cnt++;
          if (cyc - last !== W + 2)
            $display("FAIL b2b_spacing[%0d]: got %0d want %0d", done_cnt, cyc - last, W + 2);
          else pass_cnt++;
        end
        last = cyc;
        done_cnt++;
      end
      x = W'($urandom);
      y = W'($urandom);
      a = x;
      b = y;
      if (in_ready === 1'b1) q.push_back({x, y});
      tick();
      cyc++;
    end
    in_valid = 1'b0;
    total_cnt++;
    if (done_cnt !== 1000) $display("FAIL b2b_count: got %0d want 1000", done_cnt);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_mid_reset();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
